multi_player_ctrl: RTL

Parametrised per-player movement, wall-collision and sprite-render engine for NUM_PLAYERS square players. Sits between `map_rgb` (consumes the scan position and `cannot_walk_through`) and `rgb_render` (supplies player colour), replacing the fixed two-player movement path. Collisions are gathered by probing the map during the visible scan. Positions are committed once per frame, one player per cycle, during vertical blanking.

---
 rtl/multi_player_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/multi_player_ctrl.sv
// Per-player movement, wall-collision probing and sprite render for NUM_PLAYERS square players.
// Optional macro PLAYER_BLOCK_EN: players block each other's moves during UPDATE.
module multi_player_ctrl #(
  parameter int NUM_PLAYERS = 2,
  parameter int COLOR_BITS  = 24,
  parameter int SIZE        = 16,
  parameter int STEP        = 1,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480
) (
  input  logic                      clk_i,
  input  logic                      reset_ni,
  input  logic                      tick_i,
  input  logic [4*NUM_PLAYERS-1:0]  move_i,
  input  logic                      display_enable_i,
  input  logic [9:0]                hpos_i,
  input  logic [9:0]                vpos_i,
  input  logic                      cannot_walk_through_i,
  output logic [10*NUM_PLAYERS-1:0] player_x_o,
  output logic [10*NUM_PLAYERS-1:0] player_y_o,
  output logic [4*NUM_PLAYERS-1:0]  collide_o,
  output logic                      player_hit_o,
  output logic [COLOR_BITS/3-1:0]   player_red_o,
  output logic [COLOR_BITS/3-1:0]   player_green_o,
  output logic [COLOR_BITS/3-1:0]   player_blue_o,
  output logic                      frame_done_o
);

  localparam int         CW = COLOR_BITS / 3;
  localparam int         IW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam logic [9:0] SZ = 10'(SIZE);
  localparam logic [9:0] ST = 10'(STEP);

  typedef enum logic {SCAN, UPDATE} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q;
  logic          tick_pend_q, tick_held_q, frame_done_q;
  logic [9:0]    px_q   [NUM_PLAYERS];
  logic [9:0]    py_q   [NUM_PLAYERS];
  logic [3:0]    work_q [NUM_PLAYERS];
  logic [3:0]    coll_q [NUM_PLAYERS];

  logic       col_in   [NUM_PLAYERS];
  logic       row_in   [NUM_PLAYERS];
  logic [3:0] probe    [NUM_PLAYERS];
  logic [3:0] edge_blk [NUM_PLAYERS];

  logic solid, first_px, last_px, last_idx;

  assign solid    = display_enable_i && cannot_walk_through_i;
  assign first_px = display_enable_i && hpos_i == 10'd0 && vpos_i == 10'd0;
  assign last_px  = display_enable_i && hpos_i == 10'(SCREEN_W - 1) && vpos_i == 10'(SCREEN_H - 1);
  assign last_idx = idx_q == IW'(NUM_PLAYERS - 1);

  // Probe a one-pixel ring around each box; bit order {right,left,bottom,top}.
  always_comb begin
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      col_in[p]      = hpos_i >= px_q[p] && hpos_i < px_q[p] + SZ;
      row_in[p]      = vpos_i >= py_q[p] && vpos_i < py_q[p] + SZ;
      probe[p][0]    = solid && col_in[p] && vpos_i == py_q[p] - 10'd1;
      probe[p][1]    = solid && col_in[p] && vpos_i == py_q[p] + SZ;
      probe[p][2]    = solid && row_in[p] && hpos_i == px_q[p] - 10'd1;
      probe[p][3]    = solid && row_in[p] && hpos_i == px_q[p] + SZ;
      edge_blk[p][0] = py_q[p] < ST;
      edge_blk[p][1] = py_q[p] + SZ + ST > 10'(SCREEN_H);
      edge_blk[p][2] = px_q[p] < ST;
      edge_blk[p][3] = px_q[p] + SZ + ST > 10'(SCREEN_W);
    end
  end

`ifdef PLAYER_BLOCK_EN
  // Touching counts as blocked so two boxes never end up edge-to-edge.
  function automatic logic near_other(input logic [9:0] ax, input logic [9:0] ay);
    logic hit;
    hit = 1'b0;
    for (int q = 0; q < NUM_PLAYERS; q++)
      if (IW'(q) != idx_q && ax <= px_q[q] + SZ && px_q[q] <= ax + SZ &&
          ay <= py_q[q] + SZ && py_q[q] <= ay + SZ)
        hit = 1'b1;
    return hit;
  endfunction
  logic [3:0] blk_bits;
`endif

  logic [3:0] mv, cf;
  logic       go_up, go_dn, go_lf, go_rt;
  logic [9:0] cur_x, cur_y, new_x, new_y;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    mv    = move_i[4*idx_q +: 4];
    cf    = coll_q[idx_q];
    cur_x = px_q[idx_q];
    cur_y = py_q[idx_q];
    go_up = mv[0] & ~mv[1] & ~cf[0];
    go_dn = mv[1] & ~mv[0] & ~cf[1];
    go_lf = mv[2] & ~mv[3] & ~cf[2];
    go_rt = mv[3] & ~mv[2] & ~cf[3];
    new_x = cur_x;
    new_y = cur_y;
    if (go_rt)      new_x = cur_x + ST;
    else if (go_lf) new_x = cur_x - ST;
    if (go_dn)      new_y = cur_y + ST;
    else if (go_up) new_y = cur_y - ST;
`ifdef PLAYER_BLOCK_EN
    blk_bits = 4'b0;
    if ((go_rt || go_lf) && near_other(new_x, cur_y)) begin
      new_x       = cur_x;
      blk_bits[2] = go_lf;
      blk_bits[3] = go_rt;
    end
    if ((go_up || go_dn) && near_other(cur_x, new_y)) begin
      new_y       = cur_y;
      blk_bits[0] = go_up;
      blk_bits[1] = go_dn;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SCAN:    if (last_px)  state_d = UPDATE;
      UPDATE:  if (last_idx) state_d = SCAN;
      default: state_d = SCAN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= SCAN;
    else           state_q <= state_d;
  end

  // NOTE: the small position/flag arrays are registers, not RAM, so they are reset with everything else.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      idx_q        <= '0;
      tick_pend_q  <= 1'b0;
      tick_held_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        px_q[p]   <= 10'(32 + 64 * p);
        py_q[p]   <= 10'd32;
        work_q[p] <= 4'b0;
        coll_q[p] <= 4'b0;
      end
    end else begin
      frame_done_q <= 1'b0;
      if (state_q == SCAN) begin
        if (tick_i) tick_pend_q <= 1'b1;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
          work_q[p] <= first_px ? probe[p] : (work_q[p] | probe[p]);
          if (last_px) coll_q[p] <= work_q[p] | probe[p] | edge_blk[p];
        end
        if (last_px) idx_q <= '0;
      end else begin
        // Ticks seen during UPDATE belong to the next frame.
        if (tick_i) tick_held_q <= 1'b1;
        if (tick_pend_q) begin
          px_q[idx_q] <= new_x;
          py_q[idx_q] <= new_y;
`ifdef PLAYER_BLOCK_EN
          coll_q[idx_q] <= coll_q[idx_q] | blk_bits;
`endif
        end
        if (last_idx) begin
          frame_done_q <= 1'b1;
          tick_pend_q  <= tick_held_q | tick_i;
          tick_held_q  <= 1'b0;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end

  // Walk from the highest index down so the lowest overlapping index wins.
  always_comb begin
    player_hit_o   = 1'b0;
    player_red_o   = '0;
    player_green_o = '0;
    player_blue_o  = '0;
    for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
      if (display_enable_i && col_in[p] && row_in[p]) begin
        player_hit_o   = 1'b1;
        player_red_o   = {CW{p % 3 == 0}};
        player_green_o = {CW{p % 3 == 1}};
        player_blue_o  = {CW{p % 3 == 2}};
      end
    end
  end

  always_comb begin
    player_x_o = '0;
    player_y_o = '0;
    collide_o  = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      player_x_o[10*p +: 10] = px_q[p];
      player_y_o[10*p +: 10] = py_q[p];
      collide_o[4*p +: 4]    = coll_q[p];
    end
  end

  assign frame_done_o = frame_done_q;

endmodule
